// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, S-box tables, FSM encoding and the
// inverse round layers used by the iterated decryption datapath.
package present_pkg;

    localparam int PRESENT_ROUNDS = 31;
    localparam int KEY_W          = 80;
    localparam int BLK_W          = 64;
    localparam int CNT_W          = 5;

    typedef enum logic [1:0] {IDLE, KEYEXP, WHITEN, DEC} state_e;
    typedef enum logic {DIR_FWD, DIR_INV} key_dir_e;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    // Forward pLayer sends bit j to 16*j mod 63, so the inverse gathers from there.
    function automatic logic [BLK_W-1:0] inv_player(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int j = 0; j < BLK_W; j++)
            r[6'(j)] = s[(j == 63) ? 6'd63 : 6'((16 * j) % 63)];
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] inv_sbox_layer(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int n = 0; n < 16; n++)
            r[4*n +: 4] = INV_SBOX[s[4*n +: 4]];
        return r;
    endfunction

endpackage

// File: rtl/present_key_step.sv
// One PRESENT-80 key-schedule step, forward or inverse, purely combinational.
module present_key_step
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [CNT_W-1:0] counter,
    input  key_dir_e         dir,
    output logic [KEY_W-1:0] next_key
);

    logic [KEY_W-1:0] fwd;
    logic [KEY_W-1:0] tmp;

    always_comb begin
        fwd          = {key[18:0], key[79:19]};
        fwd[79:76]   = SBOX[fwd[79:76]];
        fwd[19:15]   = fwd[19:15] ^ counter;

        tmp          = key;
        tmp[19:15]   = tmp[19:15] ^ counter;
        tmp[79:76]   = INV_SBOX[tmp[79:76]];

        next_key     = (dir == DIR_INV) ? {tmp[60:0], tmp[79:61]} : fwd;
    end

endmodule

// File: rtl/present_inv_cipher.sv
// Iterative PRESENT-80 decryption: expand the key forward to K32, whiten,
// then run 31 inverse rounds while walking the schedule backwards.
module present_inv_cipher
    import present_pkg::*;
#(
    parameter int ROUNDS = PRESENT_ROUNDS
) (
    input  logic             clk,
    input  logic             iReset,
    input  logic [BLK_W-1:0] idat,
    input  logic [KEY_W-1:0] key,
    input  logic             load,
    output logic [BLK_W-1:0] odat,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS);

    state_e           fsm;
    logic [BLK_W-1:0] state_reg;
    logic [KEY_W-1:0] key_reg;
    logic [CNT_W-1:0] rnd;
    logic [KEY_W-1:0] next_key;
    logic [CNT_W-1:0] step_cnt;
    key_dir_e         step_dir;
    logic [BLK_W-1:0] round_out;

    // In DEC the key for the next round is produced with counter r-1.
    assign step_cnt  = (fsm == DEC) ? rnd - 5'd1 : rnd;
    assign step_dir  = (fsm == KEYEXP) ? DIR_FWD : DIR_INV;
    assign round_out = inv_sbox_layer(inv_player(state_reg)) ^ key_reg[79:16];

    present_key_step u_key_step (
        .key      (key_reg),
        .counter  (step_cnt),
        .dir      (step_dir),
        .next_key (next_key)
    );

    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            fsm       <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rnd       <= '0;
            odat      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: if (load) begin
                    state_reg <= idat;
                    key_reg   <= key;
                    rnd       <= 5'd1;
                    busy      <= 1'b1;
                    fsm       <= KEYEXP;
                end
                KEYEXP: begin
                    key_reg <= next_key;
                    if (rnd == LAST) fsm <= WHITEN;
                    else             rnd <= rnd + 5'd1;
                end
                WHITEN: begin
                    state_reg <= state_reg ^ key_reg[79:16];
                    key_reg   <= next_key;
                    rnd       <= LAST;
                    fsm       <= DEC;
                end
                DEC: begin
                    state_reg <= round_out;
                    if (rnd == 5'd1) begin
                        odat <= round_out;
                        done <= 1'b1;
                        busy <= 1'b0;
                        fsm  <= IDLE;
                    end else begin
                        key_reg <= next_key;
                        rnd     <= rnd - 5'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_present_inv_cipher.sv
// Scoreboard bench for present_inv_cipher: known PRESENT-80 vectors plus a
// software encryptor whose ciphertexts the DUT must decrypt back.
module tb_present_inv_cipher;

    logic        clk = 1'b0;
    logic        iReset;
    logic [63:0] idat;
    logic [79:0] key;
    logic        load;
    logic [63:0] odat;
    logic        busy;
    logic        done;

    typedef struct {
        logic [63:0] pt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] K1 = {80{1'b1}};
    localparam logic [63:0] Z  = 64'h0;
    localparam logic [63:0] O  = {64{1'b1}};

    present_inv_cipher #(.ROUNDS(31)) dut (
        .clk    (clk),
        .iReset (iReset),
        .idat   (idat),
        .key    (key),
        .load   (load),
        .odat   (odat),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
            4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
            4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
            4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
        endcase
    endfunction

    // Reference PRESENT-80 encryption.
    function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] k_in);
        logic [63:0] s, t;
        logic [79:0] k;
        s = pt;
        k = k_in;
        for (int i = 1; i <= 31; i++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
            t = '0;
            for (int j = 0; j < 64; j++) t[(j == 63) ? 63 : (16 * j) % 63] = s[j];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = sb(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(i);
        end
        return s ^ k[79:16];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation, in data and timing.
    always @(negedge clk) begin
        if (!iReset && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("odat", odat, e.pt);
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called at a negedge; load is sampled by the next rising edge.
    task automatic issue(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] pt);
        idat = ct;
        key  = k;
        load = 1'b1;
        exp_q.push_back('{pt, cyc + 64});
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within 80 cycles, expected one");
        end
    endtask

    initial begin
        iReset = 1'b1;
        load   = 1'b1;
        idat   = 64'h5579C1387B228445;
        key    = K0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_odat", odat, Z);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // Release with load already high: block starts on the first edge, done stays low.
        iReset = 1'b0;
        exp_q.push_back('{Z, cyc + 64});
        @(posedge clk);
        #1 load = 1'b0;
        check("done_after_release", 64'(done), 64'd0);
        check("busy_after_load", 64'(busy), 64'd1);
        wait_done();

        issue(64'hE72C46C0F5945049, K1, Z);
        wait_done();

        // Back-to-back with load held high; the second block's inputs arrive while busy.
        idat = 64'hA112FFC72F68417B;
        key  = K0;
        load = 1'b1;
        exp_q.push_back('{O, cyc + 64});
        exp_q.push_back('{O, cyc + 128});
        @(posedge clk);
        #1 idat = 64'h3333DCD3213210D2;
        key = K1;
        wait_done();
        @(posedge clk);
        #1 load = 1'b0;
        wait_done();

        // Load pulse and input change mid-block must be ignored.
        @(negedge clk);
        issue(64'h5579C1387B228445, K0, Z);
        repeat (8) @(posedge clk);
        #1 idat = 64'hDEADBEEFCAFEF00D;
        key  = 80'h0123456789ABCDEF0123;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);

        // Reset mid-block aborts it with no done pulse.
        issue(64'h5579C1387B228445, K0, Z);
        repeat (39) @(posedge clk);
        #1 iReset = 1'b1;
        exp_q.delete();
        #1;
        check("abort_odat", odat, Z);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        iReset = 1'b0;
        repeat (70) @(negedge clk);
        issue(64'hE72C46C0F5945049, K1, Z);
        wait_done();

        for (int n = 0; n < 1000; n++) begin
            logic [63:0] pt;
            logic [79:0] k;
            pt = {$urandom, $urandom};
            k  = {16'($urandom), $urandom, $urandom};
            issue(enc(pt, k), k, pt);
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
